// File: rtl/preg_free_list_pkg.sv
// ---------------------------------------------------------------------------
// preg_free_list_pkg
//   Constants shared by the rename/dispatch cluster (free list, busy_table,
//   rob): ROB state encodings and physical/architectural register sizing.
// ---------------------------------------------------------------------------
package preg_free_list_pkg;

   localparam int NUM_PREG   = 64;
   localparam int NUM_AREG   = 32;
   localparam int PREG_WIDTH = $clog2(NUM_PREG);

   typedef enum logic [1:0] {
      ROB_STATE_IDLE      = 2'd0,
      ROB_STATE_ROLLIBACK = 2'd1,
      ROB_STATE_WALK      = 2'd2
   } rob_state_e;

endpackage

// File: rtl/preg_free_list.sv
// ---------------------------------------------------------------------------
// preg_free_list
//   Circular queue of unmapped physical registers for rename/dispatch.
//   Up to two prds handed out per cycle, up to two old prds returned per
//   cycle by commit, and speculative allocations undone during ROB walk by
//   stepping the head pointer back (entries are not rewritten).
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   alloc_instr0/1_req   in      dispatch slots requesting a prd
//   alloc_ready          out     both slots can be served (IDLE, >=2 free)
//   alloc_instr0/1_prd   out     prds offered to slot 0 / slot 1
//   commit_free0/1_en    in      commit releases an old prd on port 0 / 1
//   commit_free0/1_prd   in      released prd
//   rob_state            in      ROB_STATE_IDLE / ROLLIBACK / WALK
//   walking_valid0/1     in      walked instrs owning a prd (head steps back)
//   walking_prd0/1       in      prds of the walked instrs (checked only)
//   free_count           out     registered number of free entries
//
// Handshake: a slot's allocation fires iff its req is high while
// alloc_ready is high in the same cycle; alloc_ready never looks at the
// reqs, and a req seen while not ready changes no state.
// ---------------------------------------------------------------------------
module preg_free_list
   import preg_free_list_pkg::*;
#(
   parameter int DEPTH     = NUM_PREG - NUM_AREG,
   parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alloc_instr0_req,
   input  logic                  alloc_instr1_req,
   output logic                  alloc_ready,
   output logic [PREG_WIDTH-1:0] alloc_instr0_prd,
   output logic [PREG_WIDTH-1:0] alloc_instr1_prd,
   input  logic                  commit_free0_en,
   input  logic [PREG_WIDTH-1:0] commit_free0_prd,
   input  logic                  commit_free1_en,
   input  logic [PREG_WIDTH-1:0] commit_free1_prd,
   input  logic [1:0]            rob_state,
   input  logic                  walking_valid0,
   input  logic                  walking_valid1,
   input  logic [PREG_WIDTH-1:0] walking_prd0,
   input  logic [PREG_WIDTH-1:0] walking_prd1,
   output logic [CNT_WIDTH-1:0]  free_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PREG_WIDTH-1:0] r_entry [DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_WIDTH-1:0]  r_count;

   logic             w_ready;
   logic             w_fire0;
   logic             w_fire1;
   logic             w_walk;
   logic [1:0]       w_n_alloc;
   logic [1:0]       w_n_free;
   logic [1:0]       w_n_walk;
   logic [PTR_W-1:0] w_tail1;
   logic [PTR_W-1:0] w_head_nxt;
   logic [PTR_W-1:0] w_tail_nxt;
   logic [CNT_WIDTH-1:0] w_count_nxt;
   logic [CNT_WIDTH:0]   w_count_sum;

   // Ready is purely a function of registered count and rob_state, so
   // dispatch can use it without a combinational loop through its reqs.
   assign w_ready = (rob_state == ROB_STATE_IDLE) && (r_count >= CNT_WIDTH'(2));
   assign w_fire0 = alloc_instr0_req && w_ready;
   assign w_fire1 = alloc_instr1_req && w_ready;
   assign w_walk  = (rob_state == ROB_STATE_WALK);

   assign w_n_alloc = {1'b0, w_fire0} + {1'b0, w_fire1};
   assign w_n_free  = {1'b0, commit_free0_en} + {1'b0, commit_free1_en};
   assign w_n_walk  = w_walk ? ({1'b0, walking_valid0} + {1'b0, walking_valid1}) : 2'd0;

   // Port 1 packs behind port 0 only when port 0 actually wrote.
   assign w_tail1 = r_tail + PTR_W'(commit_free0_en);

   // n_alloc is already zero outside IDLE, so alloc and walk never mix.
   assign w_head_nxt  = r_head + PTR_W'(w_n_alloc) - PTR_W'(w_n_walk);
   assign w_tail_nxt  = r_tail + PTR_W'(w_n_free);
   assign w_count_nxt = r_count - CNT_WIDTH'(w_n_alloc) + CNT_WIDTH'(w_n_free)
                        + CNT_WIDTH'(w_n_walk);
   // One extra bit so an overflow past DEPTH is visible to the check below.
   assign w_count_sum = {1'b0, r_count} - (CNT_WIDTH+1)'(w_n_alloc)
                        + (CNT_WIDTH+1)'(w_n_free) + (CNT_WIDTH+1)'(w_n_walk);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= PREG_WIDTH'(NUM_AREG + i);
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= CNT_WIDTH'(DEPTH);
      end else begin
         if (commit_free0_en) r_entry[r_tail]  <= commit_free0_prd;
         if (commit_free1_en) r_entry[w_tail1] <= commit_free1_prd;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign alloc_ready      = w_ready;
   assign alloc_instr0_prd = r_entry[r_head];
   // Slot 1 alone takes the head entry; with slot 0 it takes the next one.
   assign alloc_instr1_prd = r_entry[r_head + PTR_W'(alloc_instr0_req)];
   assign free_count       = r_count;

   a_walk_order: assert property (@(posedge clock) disable iff (reset)
      !(w_walk && walking_valid1 && !walking_valid0));

   a_walk_prd0: assert property (@(posedge clock) disable iff (reset)
      (w_walk && walking_valid0) |-> (r_entry[r_head - PTR_W'(1)] == walking_prd0));

   a_walk_prd1: assert property (@(posedge clock) disable iff (reset)
      (w_walk && walking_valid1) |-> (r_entry[r_head - PTR_W'(2)] == walking_prd1));

   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      w_count_sum <= (CNT_WIDTH+1)'(DEPTH));

endmodule

// File: tb/tb_preg_free_list.sv
module tb_preg_free_list;
   import preg_free_list_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       alloc_instr0_req, alloc_instr1_req, alloc_ready;
   logic [5:0] alloc_instr0_prd, alloc_instr1_prd;
   logic       commit_free0_en, commit_free1_en;
   logic [5:0] commit_free0_prd, commit_free1_prd;
   logic [1:0] rob_state;
   logic       walking_valid0, walking_valid1;
   logic [5:0] walking_prd0, walking_prd1;
   logic [5:0] free_count;

   int n_vec = 0;
   int n_err = 0;
   logic [5:0] exp_q[$];
   logic [5:0] exp_v;

   always #5 clock = ~clock;

   preg_free_list dut (
      .clock(clock), .reset(reset),
      .alloc_instr0_req(alloc_instr0_req), .alloc_instr1_req(alloc_instr1_req),
      .alloc_ready(alloc_ready),
      .alloc_instr0_prd(alloc_instr0_prd), .alloc_instr1_prd(alloc_instr1_prd),
      .commit_free0_en(commit_free0_en), .commit_free0_prd(commit_free0_prd),
      .commit_free1_en(commit_free1_en), .commit_free1_prd(commit_free1_prd),
      .rob_state(rob_state),
      .walking_valid0(walking_valid0), .walking_valid1(walking_valid1),
      .walking_prd0(walking_prd0), .walking_prd1(walking_prd1),
      .free_count(free_count)
   );

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      alloc_instr0_req = 1'b0; alloc_instr1_req = 1'b0;
      commit_free0_en  = 1'b0; commit_free0_prd = '0;
      commit_free1_en  = 1'b0; commit_free1_prd = '0;
      rob_state        = ROB_STATE_IDLE;
      walking_valid0   = 1'b0; walking_valid1 = 1'b0;
      walking_prd0     = '0;   walking_prd1   = '0;
   endtask

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      drive_idle();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      #1;
      n_vec++; if (free_count !== 6'd32) begin n_err++; $display("FAIL reset_count: got %0d expected 32", free_count); end
      n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b expected 1", alloc_ready); end
      n_vec++; if (alloc_instr0_prd !== 6'd32) begin n_err++; $display("FAIL reset_prd0: got %0d expected 32", alloc_instr0_prd); end
      n_vec++; if (alloc_instr1_prd !== 6'd32) begin n_err++; $display("FAIL reset_prd1: got %0d expected 32", alloc_instr1_prd); end
   endtask

   task automatic test_both_alloc();
      apply_reset();
      exp_q = '{6'd32, 6'd33, 6'd34, 6'd35};
      alloc_instr0_req = 1'b1; alloc_instr1_req = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         exp_v = exp_q.pop_front();
         n_vec++; if (alloc_instr0_prd !== exp_v) begin n_err++; $display("FAIL both_prd0[%0d]: got %0d expected %0d", c, alloc_instr0_prd, exp_v); end
         exp_v = exp_q.pop_front();
         n_vec++; if (alloc_instr1_prd !== exp_v) begin n_err++; $display("FAIL both_prd1[%0d]: got %0d expected %0d", c, alloc_instr1_prd, exp_v); end
         n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL both_ready[%0d]: got %0b expected 1", c, alloc_ready); end
         if (c == 0) begin
            step();
            n_vec++; if (free_count !== 6'd30) begin n_err++; $display("FAIL both_count1: got %0d expected 30", free_count); end
         end
      end
      step();
      drive_idle();
      n_vec++; if (free_count !== 6'd28) begin n_err++; $display("FAIL both_count2: got %0d expected 28", free_count); end
      // two frees in one cycle
      commit_free0_en = 1'b1; commit_free0_prd = 6'd3;
      commit_free1_en = 1'b1; commit_free1_prd = 6'd4;
      step();
      drive_idle();
      n_vec++; if (free_count !== 6'd30) begin n_err++; $display("FAIL dual_free_count: got %0d expected 30", free_count); end
   endtask

   task automatic test_slot1_only();
      apply_reset();
      alloc_instr1_req = 1'b1;
      #1;
      n_vec++; if (alloc_instr1_prd !== 6'd32) begin n_err++; $display("FAIL slot1_prd1: got %0d expected 32", alloc_instr1_prd); end
      step();
      n_vec++; if (free_count !== 6'd31) begin n_err++; $display("FAIL slot1_count: got %0d expected 31", free_count); end
      alloc_instr0_req = 1'b1;
      #1;
      n_vec++; if (alloc_instr0_prd !== 6'd33) begin n_err++; $display("FAIL slot1_next_prd0: got %0d expected 33", alloc_instr0_prd); end
      n_vec++; if (alloc_instr1_prd !== 6'd34) begin n_err++; $display("FAIL slot1_next_prd1: got %0d expected 34", alloc_instr1_prd); end
      step();
      drive_idle();
      n_vec++; if (free_count !== 6'd29) begin n_err++; $display("FAIL slot1_count2: got %0d expected 29", free_count); end
   endtask

   task automatic test_near_empty();
      apply_reset();
      alloc_instr0_req = 1'b1; alloc_instr1_req = 1'b1;
      repeat (15) step();
      n_vec++; if (free_count !== 6'd2) begin n_err++; $display("FAIL empty_count30: got %0d expected 2", free_count); end
      // one alloc plus one free in the same cycle: count holds
      alloc_instr1_req = 1'b0;
      commit_free0_en = 1'b1; commit_free0_prd = 6'd5;
      #1;
      n_vec++; if (alloc_instr0_prd !== 6'd62) begin n_err++; $display("FAIL empty_prd62: got %0d expected 62", alloc_instr0_prd); end
      step();
      commit_free0_en = 1'b0;
      n_vec++; if (free_count !== 6'd2) begin n_err++; $display("FAIL empty_hold: got %0d expected 2", free_count); end
      #1;
      n_vec++; if (alloc_instr0_prd !== 6'd63) begin n_err++; $display("FAIL empty_prd63: got %0d expected 63", alloc_instr0_prd); end
      step();
      n_vec++; if (free_count !== 6'd1) begin n_err++; $display("FAIL empty_count1: got %0d expected 1", free_count); end
      n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL empty_ready_one_req: got %0b expected 0", alloc_ready); end
      step();
      n_vec++; if (free_count !== 6'd1) begin n_err++; $display("FAIL empty_blocked_count: got %0d expected 1", free_count); end
      // head wrapped to 0, where the freed preg 5 was written by tail
      n_vec++; if (alloc_instr0_prd !== 6'd5) begin n_err++; $display("FAIL wrap_prd5: got %0d expected 5", alloc_instr0_prd); end
      alloc_instr0_req = 1'b0;
      commit_free0_en = 1'b1; commit_free0_prd = 6'd7;
      step();
      commit_free0_en = 1'b0;
      n_vec++; if (free_count !== 6'd2) begin n_err++; $display("FAIL empty_refill_count: got %0d expected 2", free_count); end
      n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL empty_refill_ready: got %0b expected 1", alloc_ready); end
      alloc_instr0_req = 1'b1; alloc_instr1_req = 1'b1;
      #1;
      n_vec++; if (alloc_instr0_prd !== 6'd5) begin n_err++; $display("FAIL wrap_pair_prd0: got %0d expected 5", alloc_instr0_prd); end
      n_vec++; if (alloc_instr1_prd !== 6'd7) begin n_err++; $display("FAIL wrap_pair_prd1: got %0d expected 7", alloc_instr1_prd); end
      step();
      drive_idle();
      n_vec++; if (free_count !== 6'd0) begin n_err++; $display("FAIL empty_zero: got %0d expected 0", free_count); end
      n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL empty_zero_ready: got %0b expected 0", alloc_ready); end
   endtask

   task automatic test_walk();
      apply_reset();
      alloc_instr0_req = 1'b1; alloc_instr1_req = 1'b1;
      step(); step();
      drive_idle();
      n_vec++; if (free_count !== 6'd28) begin n_err++; $display("FAIL walk_pre_count: got %0d expected 28", free_count); end
      n_vec++; if (alloc_instr0_prd !== 6'd36) begin n_err++; $display("FAIL walk_pre_prd0: got %0d expected 36", alloc_instr0_prd); end
      rob_state = ROB_STATE_WALK;
      walking_valid0 = 1'b1; walking_valid1 = 1'b1;
      walking_prd0 = 6'd35; walking_prd1 = 6'd34;
      #1;
      n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL walk_ready: got %0b expected 0", alloc_ready); end
      step();
      n_vec++; if (free_count !== 6'd30) begin n_err++; $display("FAIL walk_count1: got %0d expected 30", free_count); end
      n_vec++; if (alloc_instr0_prd !== 6'd34) begin n_err++; $display("FAIL walk_prd_head2: got %0d expected 34", alloc_instr0_prd); end
      walking_prd0 = 6'd33; walking_prd1 = 6'd32;
      step();
      drive_idle();
      n_vec++; if (free_count !== 6'd32) begin n_err++; $display("FAIL walk_count2: got %0d expected 32", free_count); end
      alloc_instr0_req = 1'b1; alloc_instr1_req = 1'b1;
      #1;
      n_vec++; if (alloc_instr0_prd !== 6'd32) begin n_err++; $display("FAIL walk_realloc_prd0: got %0d expected 32", alloc_instr0_prd); end
      n_vec++; if (alloc_instr1_prd !== 6'd33) begin n_err++; $display("FAIL walk_realloc_prd1: got %0d expected 33", alloc_instr1_prd); end
      n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL walk_realloc_ready: got %0b expected 1", alloc_ready); end
      step();
      drive_idle();
      n_vec++; if (free_count !== 6'd30) begin n_err++; $display("FAIL walk_realloc_count: got %0d expected 30", free_count); end
   endtask

   task automatic test_blocked();
      apply_reset();
      alloc_instr0_req = 1'b1; alloc_instr1_req = 1'b1;
      step();
      rob_state = ROB_STATE_ROLLIBACK;
      commit_free0_en = 1'b1; commit_free0_prd = 6'd10;
      #1;
      n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL rollback_ready: got %0b expected 0", alloc_ready); end
      step();
      n_vec++; if (free_count !== 6'd31) begin n_err++; $display("FAIL rollback_count: got %0d expected 31", free_count); end
      n_vec++; if (alloc_instr0_prd !== 6'd34) begin n_err++; $display("FAIL rollback_head: got %0d expected 34", alloc_instr0_prd); end
      rob_state = ROB_STATE_WALK;
      commit_free0_en = 1'b0;
      commit_free1_en = 1'b1; commit_free1_prd = 6'd11;
      #1;
      n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL walk_blk_ready: got %0b expected 0", alloc_ready); end
      step();
      n_vec++; if (free_count !== 6'd32) begin n_err++; $display("FAIL walk_blk_count: got %0d expected 32", free_count); end
      n_vec++; if (alloc_instr0_prd !== 6'd34) begin n_err++; $display("FAIL walk_blk_head: got %0d expected 34", alloc_instr0_prd); end
      drive_idle();
      #1;
      n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL blk_idle_ready: got %0b expected 1", alloc_ready); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      alloc_instr0_req = 1'b1; alloc_instr1_req = 1'b1;
      step();
      n_vec++; if (free_count !== 6'd30) begin n_err++; $display("FAIL arst_pre_count: got %0d expected 30", free_count); end
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (free_count !== 6'd32) begin n_err++; $display("FAIL arst_count: got %0d expected 32", free_count); end
      n_vec++; if (alloc_instr0_prd !== 6'd32) begin n_err++; $display("FAIL arst_prd0: got %0d expected 32", alloc_instr0_prd); end
      n_vec++; if (alloc_instr1_prd !== 6'd33) begin n_err++; $display("FAIL arst_prd1: got %0d expected 33", alloc_instr1_prd); end
      reset = 1'b0;
      drive_idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      drive_idle();
      test_reset();
      test_both_alloc();
      test_slot1_only();
      test_near_empty();
      test_walk();
      test_blocked();
      test_async_reset();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
